shift_seq: RTL and testbench
============================

# shift_seq

Serial-transmit sequencer for the 4-bit shift-register datapath. It accepts a parallel word through a valid/ready handshake and latches the shift direction with the word. It then sequences the word out one bit per cycle, MSB-first or LSB-first, with a framing strobe. It closes each frame with a completion pulse and a programmable inter-frame gap. It sits between a word-producing client and the serial line, and replaces hand-driven testbench-style sequencing of the shift register with a reusable controller.

## Interface
- `WIDTH`, default 4: word length in bits; ≥ 2.
- `GAP_CYCLES`, default 1: idle cycles inserted after each frame; ≥ 1.
- `clk_i`  in  1: single clock; all logic on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `in_valid_i`  in  1: client presents a word.
- `in_data_i`  in  WIDTH: word to transmit.
- `dir_i`  in  1: 0 = shift-left (MSB first), 1 = shift-right (LSB first); sampled only on accept.
- `in_ready_o`  out  1: controller can accept a word.
- `abort_i`  in  1: terminate the current frame.
- `data_o`  out  1: serial bit.
- `frame_o`  out  1: high while `data_o` carries a valid bit.
- `done_o`  out  1: one-cycle pulse on normal frame completion.
- `bit_idx_o`  out  $clog2(WIDTH): index of the bit currently being sent, counting 0..WIDTH-1.

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE**
  - `in_ready_o` = 1.
  - Accept occurs when `in_valid_i` && `in_ready_o` at a rising edge.
  - On accept: load `in_data_i` into the shift register, latch `dir_i`, clear the bit counter, go to SHIFT.
- **SHIFT**
  - `frame_o` = 1.
  - `data_o` = `sreg[WIDTH-1]` when dir = 0, `sreg[0]` when dir = 1.
  - Each cycle the register shifts toward the output end, zero-fill, and the counter increments.
  - After the bit with index WIDTH-1, go to GAP with the gap counter set to GAP_CYCLES-1.
- **GAP**
  - `frame_o` = 0 and `data_o` = 0.
  - `done_o` = 1 in the first GAP cycle only.
  - Decrement the gap counter; go to IDLE when it reaches 0.
- Outside SHIFT, `data_o` = 0 and `bit_idx_o` = 0.
- **`abort_i`**
  - High in SHIFT or GAP: go to IDLE at the next edge; no `done_o` pulse; the shift register is cleared.
  - In IDLE it is ignored, including when it coincides with an accept; the accept proceeds.
- `in_valid_i`/`in_data_i` are ignored while `in_ready_o` = 0; the word is not consumed.
- **Reset** (any state, including mid-frame) gives, at the next edge:
  - state IDLE, `in_ready_o` = 1;
  - `data_o`, `frame_o`, `done_o` = 0; `bit_idx_o` = 0;
  - shift register, latched dir and counters = 0.
- Reset has priority over `abort_i` and accept.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Timing
- Accept at edge T.
  - Bits appear on `data_o` during cycles T+1 .. T+WIDTH.
  - `done_o` is high in cycle T+WIDTH+1.
  - `in_ready_o` returns high in cycle T+WIDTH+GAP_CYCLES+1.
- Minimum frame-to-frame period is WIDTH+GAP_CYCLES+1 cycles (6 with defaults).
- Abort sampled at edge A: `frame_o` = 0 and `in_ready_o` = 1 from cycle A+1.

## Structure
- Package `shift_seq_pkg` holds:
  - state enum `seq_state_e` {IDLE, SHIFT, GAP};
  - direction constants `DIR_LEFT` = 1'b0 and `DIR_RIGHT` = 1'b1.
- One sub-module, `shift_seq_sreg`: the WIDTH-bit load/shift register.
  - Ports: `clk_i`, `rst_i`, `load_i`, `shift_i`, `dir_i`, `data_i[WIDTH]`, `clr_i`, `ser_o`.
  - FSM, bit counter and gap counter stay in the top level.

## Test plan
Defaults WIDTH = 4, GAP_CYCLES = 1.
- **Reset:** hold `rst_i` high for 2 cycles with `in_valid_i` = 1 → `in_ready_o` = 1, `data_o`/`frame_o`/`done_o` = 0, `bit_idx_o` = 0; no accept occurs during reset.
- **Shift-left:** accept 4'b1011, dir 0, at T → `data_o` = 1,0,1,1 in T+1..T+4 with `frame_o` = 1 and `bit_idx_o` = 0..3; `done_o` = 1 at T+5 only; `in_ready_o` = 1 at T+6.
- **Shift-right:** accept 4'b1011, dir 1 → `data_o` = 1,1,0,1.
- **Back-to-back:** `in_valid_i` held high with 4'b1100 then 4'b0011.
  - The second word is accepted at the first edge of `in_ready_o` (T+6); its bits appear in T+7..T+10.
  - `dir_i` toggled mid-frame has no effect.
- **Abort:** `abort_i` high at edge T+2 of a frame → `frame_o` = 0 and `in_ready_o` = 1 at T+3; no `done_o`; the next frame starts from a clean register.
  - Also: `abort_i` and accept together in IDLE → the accept proceeds.
- **Reset mid-frame:** `rst_i` high at edge T+3 → all outputs at reset values at T+4.
  - A new word accepted afterwards transmits correctly.
  - `in_valid_i` asserted during SHIFT/GAP does not consume the word.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the serial-transmit sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seq_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_sreg.sv
// rtl/shift_seq_sreg.sv - load/shift register with latched direction and serial tap
module shift_seq_sreg
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] sreg_q;
    logic             dir_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sreg_q <= '0;
            dir_q  <= DIR_LEFT;
        end else if (load_i) begin
            sreg_q <= data_i;
            dir_q  <= dir_i;
        end else if (shift_i) begin
            // Shift toward whichever end feeds the serial tap, zero-filling behind.
            if (dir_q == DIR_RIGHT) begin
                sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
            end else begin
                sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign ser_o = (dir_q == DIR_RIGHT) ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - serial-transmit sequencer: word handshake, framed bit stream, inter-frame gap
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     dir_i,
    output logic                     in_ready_o,
    input  logic                     abort_i,
    output logic                     data_o,
    output logic                     frame_o,
    output logic                     done_o,
    output logic [$clog2(WIDTH)-1:0] bit_idx_o
);

    localparam int IW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          done_q, done_d;
    logic          load, shift, clr;
    logic          ser;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        clr       = 1'b0;
        case (state_q)
            IDLE: begin
                // abort_i is deliberately not looked at here.
                if (in_valid_i) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    clr       = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    shift = 1'b1;
                    if (bit_cnt_q == LAST_IDX) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = GAP_INIT;
                        done_d    = 1'b1;
                        state_d   = GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + IW'(1);
                    end
                end
            end
            GAP: begin
                if (abort_i) begin
                    clr       = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shift_seq_sreg #(
        .WIDTH(WIDTH)
    ) u_sreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .shift_i(shift),
        .dir_i  (dir_i),
        .data_i (in_data_i),
        .clr_i  (clr),
        .ser_o  (ser)
    );

    assign in_ready_o = (state_q == IDLE);
    assign frame_o    = (state_q == SHIFT);
    assign data_o     = (state_q == SHIFT) && ser;
    assign bit_idx_o  = (state_q == SHIFT) ? bit_cnt_q : '0;
    assign done_o     = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - scoreboard bench for shift_seq with directed frames
module tb_shift_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         dir;
    logic         in_ready;
    logic         abort;
    logic         data;
    logic         frame;
    logic         done;
    logic [1:0]   bit_idx;

    typedef struct {
        logic b;
        int   idx;
    } bit_t;

    bit_t exp_bits[$];
    bit   exp_done[$];
    int   total = 0;
    int   bad   = 0;

    shift_seq #(.WIDTH(W), .GAP_CYCLES(1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_valid_i(in_valid),
        .in_data_i (in_data),
        .dir_i     (dir),
        .in_ready_o(in_ready),
        .abort_i   (abort),
        .data_o    (data),
        .frame_o   (frame),
        .done_o    (done),
        .bit_idx_o (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic dr, input int nbits, input bit with_done);
        bit_t e;
        for (int i = 0; i < nbits; i++) begin
            e.b   = dr ? d[i] : d[W-1-i];
            e.idx = i;
            exp_bits.push_back(e);
        end
        if (with_done) exp_done.push_back(1'b1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic dr, input int nbits, input bit with_done);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            sample;
            waited++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        dir      = dr;
        push_word(d, dr, nbits, with_done);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic frame_body(input int nbits);
        for (int k = 1; k <= nbits; k++) begin
            sample;
            check("frame_hi", {31'd0, frame}, 32'd1);
            check("ready_lo", {31'd0, in_ready}, 32'd0);
            check("done_lo_in_frame", {31'd0, done}, 32'd0);
            tick;
        end
    endtask

    task automatic tail;
        sample;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("gap_frame_lo", {31'd0, frame}, 32'd0);
        check("gap_ready_lo", {31'd0, in_ready}, 32'd0);
        tick;
        sample;
        check("ready_back", {31'd0, in_ready}, 32'd1);
        check("done_once", {31'd0, done}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_frame"}, {31'd0, frame}, 32'd0);
        check({tag, "_data"}, {31'd0, data}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idx"}, {30'd0, bit_idx}, 32'd0);
    endtask

    // Scoreboard monitor: every framed bit pops one expectation, every done pulse pops one.
    always @(negedge clk) begin
        if (frame === 1'b1) begin
            if (exp_bits.size() == 0) begin
                check("bit_expected", 32'd0, 32'd1);
            end else begin
                bit_t e;
                e = exp_bits.pop_front();
                check("sb_data", {31'd0, data}, {31'd0, e.b});
                check("sb_idx", {30'd0, bit_idx}, e.idx);
            end
        end else if (frame === 1'b0) begin
            check("idle_data_zero", {31'd0, data}, 32'd0);
            check("idle_idx_zero", {30'd0, bit_idx}, 32'd0);
        end
        if (done === 1'b1) begin
            check("done_expected", {31'd0, exp_done.size() > 0}, 32'd1);
            if (exp_done.size() > 0) void'(exp_done.pop_front());
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        dir      = 1'b0;
        abort    = 1'b0;

        // Reset held two cycles with a word offered
        tick;
        sample;
        check_idle_outputs("rst1");
        tick;
        sample;
        check_idle_outputs("rst2");
        rst      = 1'b0;
        in_valid = 1'b0;
        sample;
        check_idle_outputs("post_rst");

        // Shift-left and shift-right of the same word
        send(4'b1011, 1'b0, 4, 1'b1);
        frame_body(4);
        tail;
        send(4'b1011, 1'b1, 4, 1'b1);
        frame_body(4);
        tail;

        // Back-to-back with valid held and dir toggled mid-frame
        in_valid = 1'b1;
        in_data  = 4'b1100;
        dir      = 1'b0;
        push_word(4'b1100, 1'b0, 4, 1'b1);
        tick;
        in_data = 4'b0011;
        dir     = 1'b1;
        push_word(4'b0011, 1'b0, 4, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) dir = 1'b0;
            sample;
            check("b2b_frame_hi", {31'd0, frame}, 32'd1);
            check("b2b_ready_lo", {31'd0, in_ready}, 32'd0);
            tick;
        end
        sample;
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_gap_ready_lo", {31'd0, in_ready}, 32'd0);
        tick;
        sample;
        check("b2b_ready_t6", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        frame_body(4);
        tail;

        // Abort at edge T+2
        send(4'b1001, 1'b0, 2, 1'b0);
        sample;
        tick;
        abort = 1'b1;
        sample;
        check("abort_frame_t2", {31'd0, frame}, 32'd1);
        tick;
        abort = 1'b0;
        sample;
        check_idle_outputs("abort_t3");
        tick;
        sample;
        check("abort_no_done", {31'd0, done}, 32'd0);

        // Abort coinciding with accept in IDLE
        abort = 1'b1;
        send(4'b0110, 1'b1, 4, 1'b1);
        abort = 1'b0;
        frame_body(4);
        tail;

        // Reset at edge T+3, word offered during reset/shift must not be taken
        send(4'b1110, 1'b0, 3, 1'b0);
        sample;
        tick;
        sample;
        tick;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b0101;
        sample;
        tick;
        rst      = 1'b0;
        in_valid = 1'b0;
        sample;
        check_idle_outputs("midrst_t4");
        send(4'b0101, 1'b1, 4, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        dir      = 1'b0;
        frame_body(4);
        sample;
        check("hold_done", {31'd0, done}, 32'd1);
        tick;
        sample;
        check("hold_ready", {31'd0, in_ready}, 32'd1);
        push_word(4'b1111, 1'b0, 4, 1'b1);
        tick;
        in_valid = 1'b0;
        frame_body(4);
        tail;

        tick;
        tick;
        tick;
        check("sb_bits_drained", exp_bits.size(), 32'd0);
        check("sb_done_drained", exp_done.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
